// File: rtl/fifo_ptr_pkg.sv
// Shared definitions for async-FIFO pointer handling: default pointer
// width, default synchronizer depth, Gray decode and bit-count helpers.
package fifo_ptr_pkg;

  localparam int PTR_W_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int MAX_W           = 32;

  // Gray to binary over the full MAX_W width. Narrower codes are passed
  // zero-extended; the zero upper bits decode to zero and leave the low
  // bits correct, so one loop serves every pointer width.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Number of set bits; used to spot Gray steps touching more than one bit.
  function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      n += {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational PTR_W-wide Gray-to-binary decoder; exact inverse of the
// pointer encoder on the sending side.
module gray_to_binary
  import fifo_ptr_pkg::*;
#(
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic [PTR_W-1:0] gray_in,
  output logic [PTR_W-1:0] bin_out
);

  assign bin_out = PTR_W'(gray2bin(MAX_W'(gray_in)));

endmodule

// File: rtl/gray_ptr_sync_decoder.sv
// Receiving side of an async-FIFO pointer crossing: synchronizes a Gray
// pointer, decodes it to binary and reports how far it advanced.
// Optional macro GRAY_PTR_CHECK_EN adds a sticky gray_err output that flags
// last-stage samples differing in more than one bit.
module gray_ptr_sync_decoder
  import fifo_ptr_pkg::*;
#(
  parameter int PTR_W       = PTR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PTR_W-1:0] gray_pointer_in,
  output logic [PTR_W-1:0] bin_pointer_out,
  output logic             ptr_valid,
  output logic             ptr_changed,
  output logic [PTR_W-1:0] ptr_advance
`ifdef GRAY_PTR_CHECK_EN
  ,
  output logic             gray_err
`endif
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_STAGES);

  logic [PTR_W-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_fill;
  logic [PTR_W-1:0] w_dec;

  // ---- stage 1..SYNC_STAGES: plain flop chain, no logic between stages
  // Shift the foreign Gray pointer through the synchronizer flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= gray_pointer_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // ---- decode: last sync stage only
  gray_to_binary #(
    .PTR_W (PTR_W)
  ) u_dec (
    .gray_in (r_sync[SYNC_STAGES-1]),
    .bin_out (w_dec)
  );

  // Count edges after reset release; valid latches once the chain has
  // flushed its reset contents into the output register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_fill    <= '0;
      ptr_valid <= 1'b0;
    end else begin
      if (r_fill != CNT_FULL) begin
        r_fill <= r_fill + 1'b1;
      end
      if (r_fill == CNT_LAST) begin
        ptr_valid <= 1'b1;
      end
    end
  end

  // ---- output stage: binary pointer plus change/advance relative to it
  // Load the decoded pointer every cycle and report the modular step.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bin_pointer_out <= '0;
      ptr_changed     <= 1'b0;
      ptr_advance     <= '0;
    end else begin
      bin_pointer_out <= w_dec;
      if (ptr_valid && (w_dec != bin_pointer_out)) begin
        ptr_changed <= 1'b1;
        ptr_advance <= w_dec - bin_pointer_out;
      end else begin
        ptr_changed <= 1'b0;
        ptr_advance <= '0;
      end
    end
  end

`ifdef GRAY_PTR_CHECK_EN
  logic [PTR_W-1:0] r_gray_prev;

  // Sticky flag for any consecutive last-stage pair differing in >1 bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_gray_prev <= '0;
      gray_err    <= 1'b0;
    end else begin
      r_gray_prev <= r_sync[SYNC_STAGES-1];
      if (ptr_valid &&
          (popcount(MAX_W'(r_sync[SYNC_STAGES-1] ^ r_gray_prev)) > 1)) begin
        gray_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_ptr_sync_decoder.sv
// Directed bench for gray_ptr_sync_decoder with a pulse scoreboard.
module tb_gray_ptr_sync_decoder;

  logic       CLK;
  logic       RST;
  logic [3:0] gray_pointer_in;
  logic [3:0] bin_pointer_out;
  logic       ptr_valid;
  logic       ptr_changed;
  logic [3:0] ptr_advance;
`ifdef GRAY_PTR_CHECK_EN
  logic       gray_err;
`endif

  gray_ptr_sync_decoder #(
    .PTR_W       (4),
    .SYNC_STAGES (2)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .gray_pointer_in (gray_pointer_in),
    .bin_pointer_out (bin_pointer_out),
    .ptr_valid       (ptr_valid),
    .ptr_changed     (ptr_changed),
    .ptr_advance     (ptr_advance)
`ifdef GRAY_PTR_CHECK_EN
    ,
    .gray_err        (gray_err)
`endif
  );

  typedef struct {
    logic [3:0] bin;
    logic [3:0] adv;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] prev_bin;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drive binary index b as Gray, queue the expected pulse, check latency.
  task automatic step(input logic [3:0] b);
    exp_t e;
    gray_pointer_in = b ^ (b >> 1);
    e.bin = b;
    e.adv = b - prev_bin;
    q.push_back(e);
    prev_bin = b;
    tick(3);
    chk("step_bin", bin_pointer_out, b);
    chk("step_pulse", ptr_changed, 1);
    tick(1);
    chk("step_pulse_end", ptr_changed, 0);
  endtask

  // Monitor: every pulse must match the head of the queue; no pulse means advance 0.
  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b1) begin
      if (ptr_changed === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", ptr_changed, 0);
        end else begin
          e = q.pop_front();
          chk("pulse_bin", bin_pointer_out, e.bin);
          chk("pulse_adv", ptr_advance, e.adv);
        end
      end else begin
        chk("idle_adv", ptr_advance, 0);
      end
    end
  end

  initial begin
    logic [3:0] b;
    // Reset and fill
    RST = 1'b0;
    gray_pointer_in = 4'b0110;
    tick(2);
    chk("rst_bin", bin_pointer_out, 0);
    chk("rst_valid", ptr_valid, 0);
    chk("rst_changed", ptr_changed, 0);
    chk("rst_adv", ptr_advance, 0);
    RST = 1'b1;
    tick(1);
    chk("fill1_valid", ptr_valid, 0);
    chk("fill1_bin", bin_pointer_out, 0);
    tick(1);
    chk("fill2_valid", ptr_valid, 0);
    chk("fill2_bin", bin_pointer_out, 0);
    tick(1);
    chk("fill3_valid", ptr_valid, 1);
    chk("fill3_bin", bin_pointer_out, 4);
    chk("fill3_changed", ptr_changed, 0);
    prev_bin = 4'd4;

    // Single step 4 -> 5 with exact latency
    gray_pointer_in = 4'b0111;
    q.push_back('{bin: 4'd5, adv: 4'd1});
    prev_bin = 4'd5;
    tick(1);
    chk("lat1_bin", bin_pointer_out, 4);
    tick(1);
    chk("lat2_bin", bin_pointer_out, 4);
    chk("lat2_changed", ptr_changed, 0);
    tick(1);
    chk("lat3_bin", bin_pointer_out, 5);
    chk("lat3_changed", ptr_changed, 1);
    tick(1);
    chk("lat4_changed", ptr_changed, 0);
    chk("lat4_bin", bin_pointer_out, 5);

    // Walk 6..13 one step at a time, then wrap 14 -> 15 -> 0
    for (int i = 6; i <= 13; i++) step(4'(i));
    step(4'd14);
    step(4'd15);
    step(4'd0);
`ifdef GRAY_PTR_CHECK_EN
    chk("err_clean_walk", gray_err, 0);
`endif

    // Burst: Gray 0001 -> 0100 in one cycle
    step(4'd1);
    step(4'd7);
`ifdef GRAY_PTR_CHECK_EN
    chk("err_burst", gray_err, 1);
`endif
    step(4'd8);
    step(4'd9);
`ifdef GRAY_PTR_CHECK_EN
    chk("err_sticky", gray_err, 1);
`endif

    // Reset mid-run while bin_pointer_out = 9
    chk("pre_rst_bin", bin_pointer_out, 9);
    #2 RST = 1'b0;
    #1;
    chk("async_bin", bin_pointer_out, 0);
    chk("async_valid", ptr_valid, 0);
    chk("async_changed", ptr_changed, 0);
    chk("async_adv", ptr_advance, 0);
`ifdef GRAY_PTR_CHECK_EN
    chk("async_err", gray_err, 0);
`endif
    tick(2);
    RST = 1'b1;
    tick(2);
    chk("refill2_valid", ptr_valid, 0);
    tick(1);
    chk("refill3_valid", ptr_valid, 1);
    chk("refill3_bin", bin_pointer_out, 9);
    chk("refill3_changed", ptr_changed, 0);
    prev_bin = 4'd9;

    // Exhaustive sweep through all 16 codes
    for (int k = 1; k <= 16; k++) begin
      b = 4'(9 + k);
      step(b);
    end
`ifdef GRAY_PTR_CHECK_EN
    chk("err_sweep", gray_err, 0);
`endif
    tick(4);
    chk("queue_empty", 8'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
